// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// identifiers and the round-robin pick used when both sides request together.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   // On a tie the side that was not served last wins.
   function automatic grant_e pick_grant(input grant_e last, input logic i_req,
                                         input logic d_req);
      if (i_req && d_req) begin
         return (last == GRANT_I) ? GRANT_D : GRANT_I;
      end
      if (d_req) begin
         return GRANT_D;
      end
      return GRANT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of one shared memory port.
// state   | meaning
// IDLE    | no grant, pmem and resp outputs low, arbitrate incoming requests
// SERVE_I | instruction side owns pmem until pmem_resp
// SERVE_D | data side owns pmem until pmem_resp (write wins over read)
// RELEASE | one dead cycle so the served side drops its request
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef struct packed {
      logic              read;
      logic              write;
      logic [31:0]       address;
      logic [LINE_W-1:0] wdata;
      logic              i_resp;
      logic              d_resp;
   } arb_out_t;

   function automatic arb_out_t quiet_outputs();
      arb_out_t o;
      o = '0;
      return o;
   endfunction

   arb_state_e state;
   arb_state_e state_next;
   grant_e     last_grant;
   grant_e     last_grant_next;
   grant_e     grant_pick;
   logic       d_req;
   arb_out_t   outs;

   assign d_req      = d_read | d_write;
   assign grant_pick = pick_grant(last_grant, i_read, d_req);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         IDLE: begin
            if (i_read || d_req) begin
               last_grant_next = grant_pick;
               state_next      = (grant_pick == GRANT_D) ? SERVE_D : SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are gated by rst so reset silences everything in the same cycle.
   always_comb begin
      outs = quiet_outputs();
      if (!rst) begin
         case (state)
            SERVE_I: begin
               outs.read    = 1'b1;
               outs.address = i_address;
               outs.i_resp  = pmem_resp;
            end
            SERVE_D: begin
               outs.read    = d_read & ~d_write;
               outs.write   = d_write;
               outs.address = d_address;
               outs.wdata   = d_wdata;
               outs.d_resp  = pmem_resp;
            end
            default: outs = quiet_outputs();
         endcase
      end
   end

   assign pmem_read    = outs.read;
   assign pmem_write   = outs.write;
   assign pmem_address = outs.address;
   assign pmem_wdata   = outs.wdata;
   assign i_resp       = outs.i_resp;
   assign d_resp       = outs.d_resp;
   assign i_rdata      = rst ? '0 : pmem_rdata;
   assign d_rdata      = rst ? '0 : pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected transfers,
// a negedge monitor pops and compares them when pmem_resp completes a grant.
module tb_mem_arbiter;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write, pmem_resp;
   logic [31:0]   i_address, d_address;
   logic [LW-1:0] d_wdata, pmem_rdata;
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic          i_resp, d_resp, pmem_read, pmem_write;
   logic [31:0]   pmem_address;

   mem_arbiter #(.LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [31:0]   addr;
      logic [LW-1:0] wdata;
   } txn_t;

   txn_t exp_i[$];
   txn_t exp_d[$];
   bit   grant_log[$];
   int   n_tests = 0;
   int   n_failed = 0;
   int   mem_lat = 3;
   int   mem_cnt = 0;
   int   resp_cnt = 0;
   bit   d_resp_seen = 0;

   localparam logic [LW-1:0] JUNK = {8{32'hDEAD_BEEF}};

   function automatic logic [LW-1:0] rdata_of(input logic [31:0] addr);
      return {(LW/8){addr[7:0] ^ 8'hCB}};
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory model: answers after mem_lat cycles of an active request.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = JUNK;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !(pmem_read || pmem_write)) begin
            mem_cnt    = 0;
            pmem_resp  = 1'b0;
            pmem_rdata = JUNK;
         end else begin
            mem_cnt++;
            pmem_resp  = (mem_cnt == mem_lat);
            pmem_rdata = (mem_cnt == mem_lat) ? rdata_of(pmem_address) : JUNK;
         end
      end
   end

   task automatic sb_compare(input string side, input txn_t e, input logic [LW-1:0] rdata);
      check({side, "_addr"}, LW'(pmem_address), LW'(e.addr));
      check({side, "_wr"}, LW'(pmem_write), LW'(e.wr));
      check({side, "_rd"}, LW'(pmem_read), LW'(!e.wr));
      if (e.wr) check({side, "_wdata"}, pmem_wdata, e.wdata);
      else      check({side, "_rdata"}, rdata, rdata_of(e.addr));
   endtask

   always @(negedge clk) begin
      txn_t e;
      if (!rst) begin
         check("rw_excl", LW'(pmem_read & pmem_write), LW'(0));
         if (d_resp) d_resp_seen = 1'b1;
         if (!pmem_resp) check("resp_quiet", LW'({i_resp, d_resp}), LW'(0));
         if (pmem_resp && (pmem_read || pmem_write)) begin
            resp_cnt++;
            grant_log.push_back(d_resp);
            check("resp_onehot", LW'(i_resp ^ d_resp), LW'(1));
            if (d_resp) begin
               if (exp_d.size() == 0) check("d_unexpected", LW'(1), LW'(0));
               else begin
                  e = exp_d.pop_front();
                  sb_compare("d", e, d_rdata);
               end
            end else begin
               if (exp_i.size() == 0) check("i_unexpected", LW'(1), LW'(0));
               else begin
                  e = exp_i.pop_front();
                  sb_compare("i", e, i_rdata);
               end
            end
         end
      end
   end

   task automatic req_i(input logic [31:0] addr, input int n);
      int t;
      for (int k = 0; k < n; k++) begin
         txn_t e;
         e.wr = 1'b0; e.addr = addr + 32'(k * 32); e.wdata = '0;
         exp_i.push_back(e);
         i_read = 1'b1; i_address = e.addr;
         t = 0;
         do begin @(negedge clk); t++; end while (!i_resp && t < 200);
         check("i_wait", LW'(i_resp), LW'(1));
         @(posedge clk); #1;
         i_read = 1'b0;
         if (k < n - 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic req_d(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [LW-1:0] wdata, input int n);
      int t;
      for (int k = 0; k < n; k++) begin
         txn_t e;
         e.wr = wr; e.addr = addr + 32'(k * 32); e.wdata = wdata ^ LW'(k);
         exp_d.push_back(e);
         d_read = rd; d_write = wr; d_address = e.addr; d_wdata = e.wdata;
         t = 0;
         do begin @(negedge clk); t++; end while (!d_resp && t < 200);
         check("d_wait", LW'(d_resp), LW'(1));
         @(posedge clk); #1;
         d_read = 1'b0; d_write = 1'b0;
         if (k < n - 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic check_grants(input string tag, input int n);
      check({tag, "_ngrants"}, LW'(grant_log.size()), LW'(n));
      for (int k = 0; k < n && k < grant_log.size(); k++)
         check({tag, "_grant"}, LW'(grant_log[k]), LW'(k % 2 == 0));
   endtask

   task automatic drained(input string tag);
      check({tag, "_sb_drain"}, LW'(exp_i.size() + exp_d.size()), LW'(0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      check("rst_outs", LW'({i_resp, d_resp, pmem_read, pmem_write, |pmem_address,
                             |pmem_wdata, |i_rdata, |d_rdata}), LW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      exp_i.delete(); exp_d.delete(); grant_log.delete();
      resp_cnt = 0; d_resp_seen = 1'b0; mem_lat = 3;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0;
      do_reset();

      // single instruction read, latency and data on resp
      fork req_i(32'h0000_0060, 1); join_none
      @(negedge clk);
      check("t1_lat_n", LW'(pmem_read), LW'(0));
      @(negedge clk);
      check("t1_lat_n1", LW'(pmem_read), LW'(1));
      check("t1_addr", LW'(pmem_address), LW'(32'h60));
      wait fork;
      check("t1_ntx", LW'(resp_cnt), LW'(1));
      check("t1_no_dresp", LW'(d_resp_seen), LW'(0));
      drained("t1");

      // tie after reset grants D first
      do_reset();
      fork
         req_i(32'h0000_1000, 1);
         req_d(32'h0000_2000, 1'b1, 1'b0, '0, 1);
      join
      check_grants("t2", 2);
      check("t2_ntx", LW'(resp_cnt), LW'(2));
      drained("t2");

      // sustained tie alternates D,I,D,I,D,I
      do_reset();
      mem_lat = 2;
      fork
         req_i(32'h0000_3000, 3);
         req_d(32'h0000_4000, 1'b1, 1'b0, '0, 3);
      join
      check_grants("t3", 6);
      drained("t3");

      // read+write together performs the write only
      do_reset();
      fork req_d(32'h0000_0100, 1'b1, 1'b1, {(LW/8){8'h55}}, 1); join_none
      @(negedge clk); @(negedge clk);
      check("t4_write", LW'(pmem_write), LW'(1));
      check("t4_read", LW'(pmem_read), LW'(0));
      wait fork;
      check("t4_ntx", LW'(resp_cnt), LW'(1));
      drained("t4");

      // reset mid-transfer abandons it silently
      do_reset();
      mem_lat = 20;
      d_read = 1'b1; d_address = 32'h0000_0200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_serving", LW'(pmem_read), LW'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_outs", LW'({i_resp, d_resp, pmem_read, pmem_write, |pmem_address,
                                |i_rdata, |d_rdata}), LW'(0));
      @(posedge clk); #1;
      rst = 1'b0; d_read = 1'b0; mem_lat = 3;
      @(negedge clk);
      check("t5_idle", LW'(pmem_read | pmem_write), LW'(0));
      check("t5_no_dresp", LW'(d_resp_seen), LW'(0));
      fork
         req_i(32'h0000_5000, 1);
         req_d(32'h0000_6000, 1'b1, 1'b0, '0, 1);
      join
      check_grants("t5", 2);
      drained("t5");

      // instruction request arriving while data is served is not lost
      do_reset();
      mem_lat = 5;
      fork
         req_d(32'h0000_0300, 1'b1, 1'b0, '0, 1);
         begin
            repeat (2) @(posedge clk);
            #1;
            req_i(32'h0000_0080, 1);
         end
      join
      check_grants("t6", 2);
      drained("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
